// File: rtl/maxpool_2x2_stream_param.sv
// Streaming 2x2 pooling engine: sweeps a pooled grid, reads four-bank pixel windows
// and emits MAX/AVG pooled words with save coordinates, under a downstream stall.
module maxpool_2x2_stream_param #(
  parameter int unsigned CH        = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned OUT_ROWS  = 16,
  parameter int unsigned OUT_COLS  = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned POOL_MODE = 0,
  parameter int unsigned SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 save_stall,
  input  logic [CH*DATA_W-1:0] input_data_even_even,
  input  logic [CH*DATA_W-1:0] input_data_even_odd,
  input  logic [CH*DATA_W-1:0] input_data_odd_even,
  input  logic [CH*DATA_W-1:0] input_data_odd_odd,
  output logic                 read_pixel_signal,
  output logic [ADDR_W-1:0]    read_row_addr,
  output logic [ADDR_W-1:0]    read_col_addr,
  output logic                 save_enable,
  output logic [ADDR_W-1:0]    output_row,
  output logic [ADDR_W-1:0]    output_col,
  output logic [CH*DATA_W-1:0] output_data,
  output logic                 busy,
  output logic                 pipeline_calculation_done,
  output logic                 calculation_done
);

  localparam int unsigned BUS_W = CH * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(OUT_ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(OUT_COLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_row, rd_col;
  logic [ADDR_W-1:0] row1, col1;
  logic              v1, v2, first2, last2;
  logic [BUS_W-1:0]  win_ee, win_eo, win_oe, win_oo;

  // Sweep FSM plus two-stage pipeline; a stalled cycle leaves every register untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_row     <= '0;
      rd_col     <= '0;
      row1       <= '0;
      col1       <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      first2     <= 1'b0;
      last2      <= 1'b0;
      output_row <= '0;
      output_col <= '0;
      win_ee     <= '0;
      win_eo     <= '0;
      win_oe     <= '0;
      win_oo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= READ;
        READ: begin
          if (!save_stall) begin
            if (rd_col == LAST_COL) begin
              rd_col <= '0;
              if (rd_row == LAST_ROW) begin
                rd_row <= '0;
                state  <= DRAIN;
              end else begin
                rd_row <= rd_row + ADDR_W'(1);
              end
            end else begin
              rd_col <= rd_col + ADDR_W'(1);
            end
          end
        end
        DRAIN: if (!save_stall && v2 && last2) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!save_stall) begin
        v1   <= (state == READ);
        row1 <= rd_row;
        col1 <= rd_col;
        v2   <= v1;
        if (v1) begin
          win_ee     <= input_data_even_even;
          win_eo     <= input_data_even_odd;
          win_oe     <= input_data_odd_even;
          win_oo     <= input_data_odd_odd;
          output_row <= row1;
          output_col <= col1;
          first2     <= (row1 == '0) && (col1 == '0);
          last2      <= (row1 == LAST_ROW) && (col1 == LAST_COL);
        end
      end
    end
  end

  assign read_pixel_signal         = (state == READ) && !save_stall;
  assign read_row_addr             = rd_row;
  assign read_col_addr             = rd_col;
  assign save_enable               = v2 && !save_stall;
  assign pipeline_calculation_done = save_enable && first2;
  assign calculation_done          = save_enable && last2;
  assign busy                      = (state != IDLE);

  // Per-channel pooling of the captured window.
  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [DATA_W-1:0] p0, p1, p2, p3;
    assign p0 = win_ee[k*DATA_W +: DATA_W];
    assign p1 = win_eo[k*DATA_W +: DATA_W];
    assign p2 = win_oe[k*DATA_W +: DATA_W];
    assign p3 = win_oo[k*DATA_W +: DATA_W];

    if (POOL_MODE == 1) begin : g_avg
      localparam int unsigned SUM_W = DATA_W + 2;
      localparam logic SX = (SIGNED != 0);
      logic [SUM_W-1:0] e0, e1, e2, e3, sum;
      assign e0  = {{2{p0[DATA_W-1] & SX}}, p0};
      assign e1  = {{2{p1[DATA_W-1] & SX}}, p1};
      assign e2  = {{2{p2[DATA_W-1] & SX}}, p2};
      assign e3  = {{2{p3[DATA_W-1] & SX}}, p3};
      assign sum = e0 + e1 + e2 + e3;
      // Dropping the two LSBs of the two's-complement sum is a floor divide by 4.
      assign output_data[k*DATA_W +: DATA_W] = DATA_W'(sum >> 2);
    end else begin : g_max
      // Flipping the MSB turns a signed compare into an unsigned one.
      localparam logic [DATA_W-1:0] FLIP = (SIGNED != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
      logic [DATA_W-1:0] m01, m23;
      assign m01 = ((p0 ^ FLIP) >= (p1 ^ FLIP)) ? p0 : p1;
      assign m23 = ((p2 ^ FLIP) >= (p3 ^ FLIP)) ? p2 : p3;
      assign output_data[k*DATA_W +: DATA_W] = ((m01 ^ FLIP) >= (m23 ^ FLIP)) ? m01 : m23;
    end
  end

endmodule

// File: tb/tb_maxpool_2x2_stream_param.sv
// Bench for maxpool_2x2_stream_param: 1x1 instances for the pooling arithmetic and a
// 3x4 instance with a bank model for sweep order, stall, reset and done pulses.
module tb_maxpool_2x2_stream_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Small 1x1 instances sharing stimulus
  logic        s_start, s_stall;
  logic [31:0] s_ee, s_eo, s_oe, s_oo;
  logic        ms_rd, ms_se, ms_busy, ms_pcd, ms_cd;
  logic [15:0] ms_rr, ms_rc, ms_or, ms_oc;
  logic [31:0] ms_od;
  logic        mu_rd, mu_se, mu_busy, mu_pcd, mu_cd;
  logic [15:0] mu_rr, mu_rc, mu_or, mu_oc;
  logic [31:0] mu_od;
  logic        as_rd, as_se, as_busy, as_pcd, as_cd;
  logic [15:0] as_rr, as_rc, as_or, as_oc;
  logic [31:0] as_od;

  // 3x4 grid instance
  logic         g_start, g_stall;
  logic [127:0] g_ee = '0, g_eo = '0, g_oe = '0, g_oo = '0;
  logic         g_rd, g_se, g_busy, g_pcd, g_cd;
  logic [15:0]  g_rr, g_rc, g_or, g_oc;
  logic [127:0] g_od;
  logic [127:0] img_ee [3][4];
  logic [127:0] img_eo [3][4];
  logic [127:0] img_oe [3][4];
  logic [127:0] img_oo [3][4];

  maxpool_2x2_stream_param #(.CH(2), .DATA_W(16), .OUT_ROWS(1), .OUT_COLS(1), .ADDR_W(16),
                             .POOL_MODE(0), .SIGNED(1)) u_ms (
    .clk(clk), .rst(rst), .start(s_start), .save_stall(s_stall),
    .input_data_even_even(s_ee), .input_data_even_odd(s_eo),
    .input_data_odd_even(s_oe), .input_data_odd_odd(s_oo),
    .read_pixel_signal(ms_rd), .read_row_addr(ms_rr), .read_col_addr(ms_rc),
    .save_enable(ms_se), .output_row(ms_or), .output_col(ms_oc), .output_data(ms_od),
    .busy(ms_busy), .pipeline_calculation_done(ms_pcd), .calculation_done(ms_cd));

  maxpool_2x2_stream_param #(.CH(2), .DATA_W(16), .OUT_ROWS(1), .OUT_COLS(1), .ADDR_W(16),
                             .POOL_MODE(0), .SIGNED(0)) u_mu (
    .clk(clk), .rst(rst), .start(s_start), .save_stall(s_stall),
    .input_data_even_even(s_ee), .input_data_even_odd(s_eo),
    .input_data_odd_even(s_oe), .input_data_odd_odd(s_oo),
    .read_pixel_signal(mu_rd), .read_row_addr(mu_rr), .read_col_addr(mu_rc),
    .save_enable(mu_se), .output_row(mu_or), .output_col(mu_oc), .output_data(mu_od),
    .busy(mu_busy), .pipeline_calculation_done(mu_pcd), .calculation_done(mu_cd));

  maxpool_2x2_stream_param #(.CH(2), .DATA_W(16), .OUT_ROWS(1), .OUT_COLS(1), .ADDR_W(16),
                             .POOL_MODE(1), .SIGNED(1)) u_as (
    .clk(clk), .rst(rst), .start(s_start), .save_stall(s_stall),
    .input_data_even_even(s_ee), .input_data_even_odd(s_eo),
    .input_data_odd_even(s_oe), .input_data_odd_odd(s_oo),
    .read_pixel_signal(as_rd), .read_row_addr(as_rr), .read_col_addr(as_rc),
    .save_enable(as_se), .output_row(as_or), .output_col(as_oc), .output_data(as_od),
    .busy(as_busy), .pipeline_calculation_done(as_pcd), .calculation_done(as_cd));

  maxpool_2x2_stream_param #(.CH(8), .DATA_W(16), .OUT_ROWS(3), .OUT_COLS(4), .ADDR_W(16),
                             .POOL_MODE(0), .SIGNED(1)) u_g (
    .clk(clk), .rst(rst), .start(g_start), .save_stall(g_stall),
    .input_data_even_even(g_ee), .input_data_even_odd(g_eo),
    .input_data_odd_even(g_oe), .input_data_odd_odd(g_oo),
    .read_pixel_signal(g_rd), .read_row_addr(g_rr), .read_col_addr(g_rc),
    .save_enable(g_se), .output_row(g_or), .output_col(g_oc), .output_data(g_od),
    .busy(g_busy), .pipeline_calculation_done(g_pcd), .calculation_done(g_cd));

  // Pixel bank: data for a read appears next cycle and holds until the next read
  always @(posedge clk) begin
    if (g_rd) begin
      g_ee <= img_ee[g_rr[1:0]][g_rc[1:0]];
      g_eo <= img_eo[g_rr[1:0]][g_rc[1:0]];
      g_oe <= img_oe[g_rr[1:0]][g_rc[1:0]];
      g_oo <= img_oo[g_rr[1:0]][g_rc[1:0]];
    end
  end

  // Reference pooling of one 16-bit lane, by integer arithmetic
  function automatic logic [15:0] ref_lane(input logic [15:0] a, b, c, d,
                                           input bit avg, input bit sgn);
    int v[4];
    int m, s;
    v[0] = sgn ? int'($signed(a)) : int'(a);
    v[1] = sgn ? int'($signed(b)) : int'(b);
    v[2] = sgn ? int'($signed(c)) : int'(c);
    v[3] = sgn ? int'($signed(d)) : int'(d);
    if (avg) begin
      s = v[0] + v[1] + v[2] + v[3];
      m = (s >= 0) ? s / 4 : -((-s + 3) / 4);
    end else begin
      m = v[0];
      for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
    end
    return m[15:0];
  endfunction

  function automatic logic [127:0] ref_word(input logic [127:0] ee, eo, oe, oo,
                                            input int nch, input bit avg, input bit sgn);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < nch; k++)
      r[k*16 +: 16] = ref_lane(ee[k*16 +: 16], eo[k*16 +: 16], oe[k*16 +: 16],
                               oo[k*16 +: 16], avg, sgn);
    return r;
  endfunction

  // One 1x1 frame on all three small instances
  task automatic small_frame(input logic [31:0] ee, eo, oe, oo,
                             output logic [31:0] d_ms, d_mu, d_as);
    logic [127:0] w;
    logic [31:0] e_ms, e_mu, e_as;
    w = ref_word(128'(ee), 128'(eo), 128'(oe), 128'(oo), 2, 1'b0, 1'b1); e_ms = w[31:0];
    w = ref_word(128'(ee), 128'(eo), 128'(oe), 128'(oo), 2, 1'b0, 1'b0); e_mu = w[31:0];
    w = ref_word(128'(ee), 128'(eo), 128'(oe), 128'(oo), 2, 1'b1, 1'b1); e_as = w[31:0];
    @(negedge clk);
    s_ee = ee; s_eo = eo; s_oe = oe; s_oo = oo; s_start = 1'b1;
    @(negedge clk); s_start = 1'b0; #1;
    n_checks++;
    if ({ms_rd, ms_rr, ms_rc, ms_busy, ms_se, mu_rd, mu_rr, mu_rc, mu_busy, mu_se,
         as_rd, as_rr, as_rc, as_busy, as_se} !== {3{1'b1, 16'd0, 16'd0, 1'b1, 1'b0}})
      $display("FAIL small_read: got rd=%b%b%b busy=%b%b%b se=%b%b%b, want read (0,0) busy",
               ms_rd, mu_rd, as_rd, ms_busy, mu_busy, as_busy, ms_se, mu_se, as_se);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({ms_se, mu_se, as_se} !== 3'b000)
      $display("FAIL small_early_save: got %b want 000", {ms_se, mu_se, as_se});
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({ms_se, ms_pcd, ms_cd, ms_or, ms_oc, mu_se, mu_pcd, mu_cd, mu_or, mu_oc,
         as_se, as_pcd, as_cd, as_or, as_oc} !== {3{3'b111, 16'd0, 16'd0}})
      $display("FAIL small_save_ctrl: se=%b%b%b pcd=%b%b%b cd=%b%b%b want all 1 at (0,0)",
               ms_se, mu_se, as_se, ms_pcd, mu_pcd, as_pcd, ms_cd, mu_cd, as_cd);
    else n_pass++;
    n_checks++;
    if ({ms_od, mu_od, as_od} !== {e_ms, e_mu, e_as})
      $display("FAIL small_data: got %h %h %h want %h %h %h", ms_od, mu_od, as_od,
               e_ms, e_mu, e_as);
    else n_pass++;
    d_ms = ms_od; d_mu = mu_od; d_as = as_od;
    @(negedge clk); #1;
    n_checks++;
    if ({ms_busy, mu_busy, as_busy, ms_se, mu_se, as_se} !== 6'b0)
      $display("FAIL small_idle: busy=%b%b%b se=%b%b%b want 0", ms_busy, mu_busy, as_busy,
               ms_se, mu_se, as_se);
    else n_pass++;
  endtask

  // One 3x4 frame: checks read order, save order/data, done pulses, busy and latency
  task automatic grid_frame(input bit stall_en, input int reset_at, input bit poke_start);
    int reads = 0, saves = 0, first_cyc = -1, last_cyc = -1, stalls = 0;
    int stall_a = 3, stall_b = 1, r, c;
    bit fin = 0, aborted = 0;
    logic [127:0] exp_d;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) begin
        img_ee[i][j] = {$urandom(), $urandom(), $urandom(), $urandom()};
        img_eo[i][j] = {$urandom(), $urandom(), $urandom(), $urandom()};
        img_oe[i][j] = {$urandom(), $urandom(), $urandom(), $urandom()};
        img_oo[i][j] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    @(negedge clk);
    g_start = 1'b1; g_stall = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      g_start = poke_start && (cyc == 6 || saves == 11);
      g_stall = 1'b0;
      if (stall_en && saves == 5 && stall_a > 0) begin
        g_stall = 1'b1; stall_a--; stalls++;
      end else if (stall_en && reads == 12 && saves < 12 && stall_b > 0) begin
        g_stall = 1'b1; stall_b--; stalls++;
      end
      #1;
      if (fin) begin
        n_checks++;
        if ({g_busy, g_se} !== 2'b00)
          $display("FAIL grid_end_idle: busy=%b se=%b want 0 0", g_busy, g_se);
        else n_pass++;
        break;
      end
      if (g_stall) begin
        n_checks++;
        if ({g_rd, g_se, g_pcd, g_cd} !== 4'b0)
          $display("FAIL grid_stall_quiet: rd=%b se=%b pcd=%b cd=%b want 0", g_rd, g_se,
                   g_pcd, g_cd);
        else n_pass++;
      end
      if (g_rd) begin
        n_checks++;
        if (reads >= 12 || g_rr !== 16'(reads / 4) || g_rc !== 16'(reads % 4))
          $display("FAIL grid_read_order: got (%0d,%0d) want read #%0d at (%0d,%0d)",
                   g_rr, g_rc, reads, reads / 4, reads % 4);
        else n_pass++;
        reads++;
      end
      if (g_se) begin
        r = saves / 4; c = saves % 4;
        exp_d = ref_word(img_ee[r][c], img_eo[r][c], img_oe[r][c], img_oo[r][c], 8, 1'b0, 1'b1);
        n_checks++;
        if (saves >= 12 || {g_or, g_oc, g_pcd, g_cd} !==
            {16'(r), 16'(c), (saves == 0), (saves == 11)})
          $display("FAIL grid_save_ctrl: got (%0d,%0d) pcd=%b cd=%b want save #%0d at (%0d,%0d)",
                   g_or, g_oc, g_pcd, g_cd, saves, r, c);
        else n_pass++;
        n_checks++;
        if (g_od !== exp_d)
          $display("FAIL grid_save_data: got %h want %h at (%0d,%0d)", g_od, exp_d, r, c);
        else n_pass++;
        if (saves == 0) first_cyc = cyc;
        if (saves == 11) begin last_cyc = cyc; fin = 1; end
        saves++;
        if (saves - 1 == reset_at) begin
          rst = 1'b1; #1;
          n_checks++;
          if ({g_rd, g_rr, g_rc, g_se, g_or, g_oc, g_od, g_busy, g_pcd, g_cd} !== '0)
            $display("FAIL grid_async_reset: rd=%b se=%b busy=%b row=%0d col=%0d data=%h want 0",
                     g_rd, g_se, g_busy, g_or, g_oc, g_od);
          else n_pass++;
          g_start = 1'b0;
          @(negedge clk); rst = 1'b0;
          aborted = 1;
          break;
        end
      end else begin
        n_checks++;
        if ({g_pcd, g_cd} !== 2'b00)
          $display("FAIL grid_done_no_save: pcd=%b cd=%b want 0 0", g_pcd, g_cd);
        else n_pass++;
      end
      n_checks++;
      if (g_busy !== 1'b1) $display("FAIL grid_busy: got %b want 1 in frame", g_busy);
      else n_pass++;
    end
    g_start = 1'b0; g_stall = 1'b0;
    if (!aborted) begin
      n_checks++;
      if (!fin || first_cyc != 3 || last_cyc != 14 + stalls)
        $display("FAIL grid_timing: fin=%0d first=%0d last=%0d want 1 3 %0d", fin, first_cyc,
                 last_cyc, 14 + stalls);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if ({ms_rd, ms_se, ms_busy, ms_pcd, ms_cd, ms_od, ms_or, ms_oc, as_od,
         g_rd, g_rr, g_rc, g_se, g_or, g_oc, g_od, g_busy, g_pcd, g_cd} !== '0)
      $display("FAIL reset_state: grid rd=%b se=%b busy=%b data=%h small=%h want 0",
               g_rd, g_se, g_busy, g_od, ms_od);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_max_signed();
    logic [31:0] a, b, c;
    small_frame({16'h8000, 16'hFFFD}, {16'h7FFF, 16'h0005},
                {16'h0000, 16'hFFF9}, {16'hFFFF, 16'h0002}, a, b, c);
    n_checks++;
    if (a !== 32'h7FFF_0005) $display("FAIL max_signed: got %h want 7fff0005", a);
    else n_pass++;
  endtask

  task automatic test_max_unsigned();
    logic [31:0] a, b, c;
    small_frame({16'h8000, 16'hFFFD}, {16'h7FFF, 16'h0005},
                {16'h0000, 16'hFFF9}, {16'hFFFF, 16'h0002}, a, b, c);
    n_checks++;
    if (b !== 32'hFFFF_FFFD) $display("FAIL max_unsigned: got %h want fffffffd", b);
    else n_pass++;
  endtask

  task automatic test_avg();
    logic [31:0] a, b, c;
    small_frame({16'hFFFF, 16'h0001}, {16'hFFFE, 16'h0002},
                {16'hFFFE, 16'h0003}, {16'hFFFE, 16'h0004}, a, b, c);
    n_checks++;
    if (c !== 32'hFFFE_0002) $display("FAIL avg_floor: got %h want fffe0002", c);
    else n_pass++;
  endtask

  task automatic test_random_windows();
    logic [31:0] a, b, c;
    for (int i = 0; i < 12; i++)
      small_frame($urandom(), $urandom(), $urandom(), $urandom(), a, b, c);
  endtask

  task automatic test_grid();
    grid_frame(1'b0, -1, 1'b0);
  endtask

  task automatic test_stall();
    grid_frame(1'b1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    grid_frame(1'b0, 6, 1'b0);
    grid_frame(1'b0, -1, 1'b1);
  endtask

  initial begin
    s_start = 1'b0; s_stall = 1'b0; g_start = 1'b0; g_stall = 1'b0;
    s_ee = '0; s_eo = '0; s_oe = '0; s_oo = '0;
    test_reset();
    test_max_signed();
    test_max_unsigned();
    test_avg();
    test_random_windows();
    test_grid();
    test_stall();
    test_reset_mid_frame();
    test_grid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
